tqvp_pwm_multi: RTL

Multi-channel PWM peripheral for the TinyQV peripheral bus. It is the parametrised successor of the two-channel fixed-period PWM. Features:
- Up to 8 channels sharing one prescaler and one 8-bit period counter.
- Edge-aligned or center-aligned modes.
- Double-buffered duty registers, loaded at the period boundary.
- Per-channel polarity and enable masks.
- Sticky period-wrap status flag.

---
 rtl/tqvp_pwm_multi.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/tqvp_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module  : tqvp_pwm_multi
// Brief   : Multi-channel PWM for the TinyQV peripheral bus; shared prescaler
//           and period counter, edge/center modes, double-buffered duty.
//           Optional macro PWM_EXT_SYNC_EN: ui_in[1] rising edge restarts.
// Rev     : 1.0  initial release
// ============================================================================
module tqvp_pwm_multi #(
    parameter int NUM_CH     = 4,
    parameter int PRESCALE_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam logic [PRESCALE_W-1:0] c_PRE_ONE = 1;
    localparam logic [7:0]            c_CNT_ONE = 8'd1;

    logic [7:0]            r_duty_shadow [NUM_CH];
    logic [7:0]            r_duty_active [NUM_CH];
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [PRESCALE_W-1:0] w_pre_nxt;
    logic [7:0]            r_top;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_nxt;
    logic                  r_en;
    logic                  r_en_prev;
    logic                  r_center;
    logic                  r_mode;
    logic                  r_dir_down;
    logic                  w_dir_nxt;
    logic                  r_wrap;
    logic                  w_tick;
    logic                  w_boundary;
    logic                  w_sync_en;
    logic                  w_sync_restart;
    logic [NUM_CH-1:0]     r_pol;
    logic [NUM_CH-1:0]     r_ch_en;
    logic [NUM_CH-1:0]     r_pwm;
    logic                  w_unused;

    assign w_unused = &{1'b0, ui_in};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_duty_shadow[i] <= '0;
            r_prescale <= '0;
            r_top      <= '0;
            r_en       <= 1'b0;
            r_center   <= 1'b0;
            r_pol      <= '0;
            r_ch_en    <= '0;
            r_wrap     <= 1'b0;
        end else begin
            if (data_write) begin
                case (address)
                    4'h8: r_prescale[7:0]            <= data_in;
                    4'h9: r_prescale[PRESCALE_W-1:8] <= data_in[PRESCALE_W-9:0];
                    4'hA: r_top                      <= data_in;
                    4'hB: begin
                        r_en     <= data_in[0];
                        r_center <= data_in[1];
                    end
                    4'hC: r_pol   <= data_in[NUM_CH-1:0];
                    4'hD: r_ch_en <= data_in[NUM_CH-1:0];
                    default: begin
                        for (int i = 0; i < NUM_CH; i++)
                            if (address == 4'(i)) r_duty_shadow[i] <= data_in;
                    end
                endcase
            end
            // a wrap in the same cycle as the W1C write must not be lost
            if (w_boundary)
                r_wrap <= 1'b1;
            else if (data_write && address == 4'hE && data_in[0])
                r_wrap <= 1'b0;
        end
    end

`ifdef PWM_EXT_SYNC_EN
    logic r_sync_en;
    logic r_sync_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync_en   <= 1'b0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync_prev <= ui_in[1];
            if (data_write && address == 4'hB) r_sync_en <= data_in[2];
        end
    end

    assign w_sync_en      = r_sync_en;
    assign w_sync_restart = r_en && r_sync_en && ui_in[1] && !r_sync_prev;
`else
    assign w_sync_en      = 1'b0;
    assign w_sync_restart = 1'b0;
`endif

    always_comb begin
        data_out = '0;
        case (address)
            4'h8: data_out = r_prescale[7:0];
            4'h9: data_out[PRESCALE_W-9:0] = r_prescale[PRESCALE_W-1:8];
            4'hA: data_out = r_top;
            4'hB: data_out = {5'b0, w_sync_en, r_center, r_en};
            4'hC: data_out = 8'(r_pol);
            4'hD: data_out = 8'(r_ch_en);
            4'hE: data_out = {7'b0, r_wrap};
            default: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (address == 4'(i)) data_out = r_duty_shadow[i];
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Prescaler and period counter
    // ------------------------------------------------------------------
    always_comb begin
        w_tick    = 1'b0;
        w_pre_nxt = r_pre_cnt;
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir_down;
        if (r_en) begin
            if (r_pre_cnt >= r_prescale) begin
                w_tick    = 1'b1;
                w_pre_nxt = '0;
            end else begin
                w_pre_nxt = r_pre_cnt + c_PRE_ONE;
            end
        end
        if (w_tick) begin
            // r_mode remembers the mode the counter is running in, so a
            // center-bit flip restarts the sequence cleanly
            if (r_en_prev && (r_center != r_mode)) begin
                w_cnt_nxt = '0;
                w_dir_nxt = 1'b0;
            end else if (!r_center) begin
                w_cnt_nxt = (r_cnt >= r_top) ? '0 : r_cnt + c_CNT_ONE;
                w_dir_nxt = 1'b0;
            end else if (r_top == '0) begin
                w_cnt_nxt = '0;
                w_dir_nxt = 1'b0;
            end else if (!r_dir_down && (r_cnt < r_top)) begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end else begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
                w_dir_nxt = (w_cnt_nxt != '0);
            end
        end
        w_boundary = w_tick && (w_cnt_nxt == '0);
        if (w_sync_restart) begin
            w_pre_nxt  = '0;
            w_cnt_nxt  = '0;
            w_dir_nxt  = 1'b0;
            w_boundary = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre_cnt  <= '0;
            r_cnt      <= '0;
            r_dir_down <= 1'b0;
            r_mode     <= 1'b0;
            r_en_prev  <= 1'b0;
        end else begin
            r_en_prev <= r_en;
            if (!r_en) begin
                r_pre_cnt  <= '0;
                r_cnt      <= '0;
                r_dir_down <= 1'b0;
                r_mode     <= r_center;
            end else begin
                r_pre_cnt  <= w_pre_nxt;
                r_cnt      <= w_cnt_nxt;
                r_dir_down <= w_dir_nxt;
                if (!r_en_prev || w_tick) r_mode <= r_center;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel compare and output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_duty_active[i] <= '0;
            r_pwm <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // tracking the shadow while disabled makes the first enabled
                // cycle already compare against the freshly loaded duty
                if (!r_en || !r_en_prev || w_boundary)
                    r_duty_active[i] <= r_duty_shadow[i];
                r_pwm[i] <= (r_en && r_ch_en[i]) ?
                            ((r_cnt < r_duty_active[i]) ^ r_pol[i]) : r_pol[i];
            end
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_uo
        assign uo_out[i] = r_pwm[i % NUM_CH];
    end

endmodule
`default_nettype wire
